// File: rtl/core_pkg.sv
// Shared decode constants: imm_sel encodings, default datapath width and the
// occupancy states of the immediate pipe's output buffer.
package core_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational RV32I/RV64I immediate extraction; every format sign-extends
// from instr[31], so RV64 LUI/AUIPC get the architected 64-bit value.
module imm_extract
    import core_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] raw;
    logic        unused_opcode;

    assign unused_opcode = ^instr[6:0];

    always_comb begin
        raw     = '0;
        illegal = 1'b0;
        case (imm_sel)
            IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   raw = {instr[31:12], 12'b0};
            IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: illegal = 1'b1;
        endcase
    end

    assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: extract + pc-relative add, then a main
// output register backed by one skid register so in_ready is a pure flop.
module imm_gen_pipe
    import core_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_sel,
    input  logic [XLEN-1:0]  pc,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [XLEN-1:0]  target_out,
    output logic             illegal_out,
    output logic [TAG_W-1:0] tag_out,
    output logic [1:0]       state_dbg
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  target;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    pipe_state_t     state;
    entry_t          new_e;
    entry_t          main_q;
    entry_t          skid_q;
    logic [XLEN-1:0] new_imm;
    logic            new_ill;
    logic            accept;
    logic            drain;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (instr),
        .imm_sel (imm_sel),
        .imm     (new_imm),
        .illegal (new_ill)
    );

    // Illegal selects yield imm = 0, so the adder already gives target = pc.
    assign new_e.imm     = new_imm;
    assign new_e.target  = pc + new_imm;
    assign new_e.illegal = new_ill;
    assign new_e.tag     = tag_in;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Valid/ready: a beat transfers on any edge where valid & ready are both
    // high; in_ready and out_valid are registered, never derived from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q    <= new_e;
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_q <= new_e;
                    end else if (accept) begin
                        skid_q   <= new_e;
                        in_ready <= 1'b0;
                        state    <= ST_FULL;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can occur.
                    if (drain) begin
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        state    <= ST_ONE;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign imm_out     = main_q.imm;
    assign target_out  = main_q.target;
    assign illegal_out = main_q.illegal;
    assign tag_out     = main_q.tag;
    assign state_dbg   = state;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_imm_gen_pipe;
    import core_pkg::*;

    localparam int TAG_W = 5;
    localparam int EW    = 64 + 64 + 1 + TAG_W;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid  = 1'b0;
    logic             flush     = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      instr     = '0;
    logic [2:0]       imm_sel   = '0;
    logic [63:0]      pc        = '0;
    logic [TAG_W-1:0] tag_in    = '0;

    logic             in_ready32, out_valid32, ill32;
    logic [31:0]      imm32, tgt32;
    logic [TAG_W-1:0] tag32;
    logic [1:0]       state32;
    logic             in_ready64, out_valid64, ill64;
    logic [63:0]      imm64, tgt64;
    logic [TAG_W-1:0] tag64;
    logic [1:0]       state64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .imm_sel(imm_sel), .pc(pc[31:0]), .tag_in(tag_in),
        .flush(flush), .out_valid(out_valid32), .out_ready(out_ready),
        .imm_out(imm32), .target_out(tgt32), .illegal_out(ill32),
        .tag_out(tag32), .state_dbg(state32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_sel(imm_sel), .pc(pc), .tag_in(tag_in),
        .flush(flush), .out_valid(out_valid64), .out_ready(out_ready),
        .imm_out(imm64), .target_out(tgt64), .illegal_out(ill64),
        .tag_out(tag64), .state_dbg(state64)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // reference model: immediate value straight from the ISA format tables
    function automatic logic [63:0] model_imm(input logic [31:0] w, input logic [2:0] sel);
        case (sel)
            3'd0:    return 64'($signed(w[31:20]));
            3'd1:    return 64'($signed({w[31:25], w[11:7]}));
            3'd2:    return 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            3'd3:    return 64'($signed({w[31:12], 12'b0}));
            3'd4:    return 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [EW-1:0] make_entry(input logic [31:0] w, input logic [2:0] sel,
                                                 input logic [63:0] p, input logic [TAG_W-1:0] t);
        logic [63:0] im;
        im = model_imm(w, sel);
        return {im, p + im, (sel > 3'd4), t};
    endfunction

    // model update: a two-deep FIFO with flush and async reset
    always @(posedge clk or negedge rst_n) begin
        bit m_acc, m_drn;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            m_acc = in_valid && (exp_q.size() < 2);
            m_drn = (exp_q.size() > 0) && out_ready;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_drn) void'(exp_q.pop_front());
                if (m_acc) exp_q.push_back(make_entry(instr, imm_sel, pc, tag_in));
            end
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        logic [EW-1:0]    e;
        logic [63:0]      e_imm, e_tgt;
        logic             e_ill;
        logic [TAG_W-1:0] e_tag;
        if (rst_n) begin
            check("out_valid32", out_valid32, exp_q.size() > 0);
            check("in_ready32",  in_ready32,  exp_q.size() < 2);
            check("out_valid64", out_valid64, exp_q.size() > 0);
            check("in_ready64",  in_ready64,  exp_q.size() < 2);
            if (exp_q.size() > 0) begin
                e     = exp_q[0];
                e_imm = e[EW-1 -: 64];
                e_tgt = e[EW-65 -: 64];
                e_ill = e[TAG_W];
                e_tag = e[TAG_W-1:0];
                check("imm32", imm32, {32'd0, e_imm[31:0]});
                check("tgt32", tgt32, {32'd0, e_tgt[31:0]});
                check("ill32", ill32, e_ill);
                check("tag32", tag32, e_tag);
                check("imm64", imm64, e_imm);
                check("tgt64", tgt64, e_tgt);
                check("ill64", ill64, e_ill);
                check("tag64", tag64, e_tag);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [31:0] w, input logic [2:0] sel,
                        input logic [63:0] p, input logic [TAG_W-1:0] t);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        instr    = w;
        imm_sel  = sel;
        pc       = p;
        tag_in   = t;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready32;
            step();
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid32, 0);
        check({tag, "_ready"}, in_ready32, 1);
        check({tag, "_imm"}, imm32, 0);
        check({tag, "_tgt"}, tgt32, 0);
        check({tag, "_ill"}, ill32, 0);
        check({tag, "_tag"}, tag32, 0);
        check({tag, "_imm64"}, imm64, 0);
        check({tag, "_valid64"}, out_valid64, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

        // directed format cases with hand-computed results
        send(32'hFFF00093, IMM_I, 64'h0, 5'd1);
        @(negedge clk);
        check("dir_i_imm", imm32, 64'hFFFFFFFF);
        check("dir_i_tgt", tgt32, 64'hFFFFFFFF);
        check("dir_i_ill", ill32, 0);
        step();
        send(32'hFE20AE23, IMM_S, 64'h0, 5'd2);
        @(negedge clk);
        check("dir_s_imm", imm32, 64'hFFFFFFFC);
        step();
        send(32'hFE000CE3, IMM_B, 64'h100, 5'd3);
        @(negedge clk);
        check("dir_b_imm", imm32, 64'hFFFFFFF8);
        check("dir_b_tgt", tgt32, 64'h000000F8);
        step();
        send(32'h0010006F, IMM_J, 64'h1000, 5'd4);
        @(negedge clk);
        check("dir_j_imm", imm32, 64'h800);
        check("dir_j_tgt", tgt32, 64'h1800);
        step();
        send(32'h800000B7, IMM_U, 64'h10, 5'd5);
        @(negedge clk);
        check("dir_u_imm64", imm64, 64'hFFFFFFFF80000000);
        check("dir_u_tgt64", tgt64, 64'hFFFFFFFF80000010);
        check("dir_u_imm32", imm32, 64'h80000000);
        step();
        send(32'h12345678, 3'b110, 64'h12345678, 5'd6);
        @(negedge clk);
        check("dir_ill_flag", ill32, 1);
        check("dir_ill_imm", imm32, 0);
        check("dir_ill_tgt", tgt32, 64'h12345678);
        step();

        // back-pressure: three back-to-back offers with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_sel   = IMM_I;
        pc        = 64'h0;
        instr     = 32'h00100093;
        step();
        instr = 32'h00200093;
        step();
        instr = 32'h00300093;
        @(negedge clk);
        check("bp_ready_low", in_ready32, 0);
        check("bp_head", imm32, 64'h1);
        step();
        @(negedge clk);
        check("bp_still_low", in_ready32, 0);
        check("bp_head_stable", imm32, 64'h1);
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_second", imm32, 64'h2);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_third", imm32, 64'h3);
        step();

        // flush while FULL with a new offer pending
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00400093;
        step();
        instr = 32'h00500093;
        step();
        instr = 32'h00600093;
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", out_valid32, 0);
        check("flush_ready", in_ready32, 1);
        step();
        out_ready = 1'b1;
        repeat (4) step();

        // randomized stream with a mid-stream async reset pulse
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            instr     = $urandom;
            imm_sel   = 3'($urandom_range(0, 7));
            pc        = {$urandom, $urandom};
            tag_in    = 5'($urandom);
            if (i == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("async_rst");
                @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the pipelined core's decode stage. Extracts and sign-extends the immediate for all RV32I/RV64I base formats (I, S, B, U, J) to XLEN bits. Computes the PC-relative target (pc + imm) for branch, jump and AUIPC use. Results are registered behind a valid/ready handshake with a two-entry skid buffer, so IF/ID back-pressure never creates a combinational ready path.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the opaque sideband tag (e.g. rd index) carried alongside each result.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept; registered.
- instr  in  32  raw instruction word.
- imm_sel  in  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J; 101–111 illegal.
- pc  in  XLEN  PC of instr.
- tag_in  in  TAG_W  sideband, passed through.
- flush  in  1  synchronous kill of all held and incoming entries.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- imm_out  out  XLEN  sign-extended immediate.
- target_out  out  XLEN  pc + imm_out, modulo 2^XLEN.
- illegal_out  out  1  imm_sel was 101–111.
- tag_out  out  TAG_W  tag of the presented result.

## Operation
- Format extraction, always sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
- Illegal imm_sel: imm = 0, target = pc, illegal_out = 1. The entry still flows through the pipe.
- target = pc + imm, XLEN-bit, carry discarded (wrap-around).
- Storage is a main output register plus one skid register. States:
  - EMPTY: out_valid = 0, in_ready = 1.
  - ONE: main valid, skid empty, in_ready = 1.
  - FULL: both valid, in_ready = 0.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept, no drain → FULL (new entry goes to skid).
  - ONE + drain, no accept → EMPTY.
  - ONE + accept + drain → ONE (main reloaded).
  - FULL + drain → ONE (skid moves to main).
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Ordering is strict FIFO; the skid entry is never presented before main.
- flush: on the next edge both entries are invalidated, giving EMPTY with in_ready = 1. Any input accepted in the same cycle is discarded. A drain in the flush cycle still completes for the entry presented that cycle.
- XLEN = 64: the U immediate is sign-extended from bit 31 (RV64 LUI semantics).

## Timing
- Latency: accepted in cycle N, presented on outputs in cycle N+1.
- Throughput: 1 per cycle while out_ready = 1.
- in_ready and all outputs come directly from flops. There is no combinational path from out_ready to in_ready.
- Outputs are held stable while out_valid = 1 and out_ready = 0.
- Reset (async assert, sync-released deassert):
  - out_valid = 0, in_ready = 1, illegal_out = 0.
  - imm_out, target_out and tag_out = 0.
  - State = EMPTY.
- Reset mid-transfer drops all entries; there is no partial output.
- Simultaneous accept and drain in FULL cannot occur, because in_ready = 0 in FULL.
- The only critical path is the XLEN-bit adder from the input register side; it sits before the main/skid registers.

## Structure
- Shared package (core_pkg): imm_sel encodings (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J) as 3-bit constants, and the default XLEN. The control unit uses the same constants.
- One sub-module, imm_extract: combinational format mux plus sign-extension, parameterised by XLEN.
- The handshake, skid buffer and adder live in imm_gen_pipe.

## Test plan
- XLEN = 32, I format, instr 0xFFF00093, pc 0x0 → one cycle later imm_out 0xFFFFFFFF, target 0xFFFFFFFF, illegal_out 0.
- S instr 0xFE20AE23 → imm 0xFFFFFFFC. B instr 0xFE000CE3, pc 0x100 → imm 0xFFFFFFF8, target 0x000000F8.
- J instr 0x0010006F, pc 0x1000 → imm 0x800, target 0x1800. XLEN = 64, U instr 0x800000B7 → imm 0xFFFFFFFF80000000.
- Back-pressure: hold out_ready = 0 and offer 3 instrs back-to-back.
  - in_ready drops after the 2nd is accepted; the 3rd is held upstream.
  - Release out_ready: all 3 emerge in order with outputs stable while stalled.
- flush asserted while FULL with in_valid = 1 → next cycle out_valid = 0, in_ready = 1. Neither held nor incoming entry ever appears.
- imm_sel 110 → illegal_out 1, imm 0, target = pc. Async rst_n pulse mid-stream → outputs 0 and out_valid 0 immediately.
